// File: rtl/flash_seq.sv
// flash_seq: burst sequencer that turns (addr, len, dir) into single-byte
// flash controller requests. Define FLASH_SEQ_VERIFY_EN to read back every write.
module flash_seq #(
  parameter int ACK_TIMEOUT = 4,
  parameter int WRITE_GAP   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        dir,
  input  logic [15:0] base_addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic        fc_read,
  output logic        fc_write,
  output logic [15:0] fc_addr,
  output logic [7:0]  fc_din,
  input  logic [7:0]  fc_dout,
  input  logic        fc_busy
);

  typedef enum logic [3:0] {
    IDLE, GET, REQ, WAIT_ACK, WAIT_DONE, DELIVER, GAP, VERIFY, DONE
  } state_t;

  localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(WRITE_GAP - 1);
  localparam bit          GAP_EN   = (WRITE_GAP != 0);

  state_t      state_r, state_s;
  logic        dir_r, dir_s;
  logic [15:0] addr_r, addr_s;
  logic [15:0] remaining_r, remaining_s;
  logic [15:0] timer_r, timer_s;
  logic        error_r, error_s;
  logic [7:0]  rd_data_r, rd_data_s;
  logic [7:0]  fc_din_r, fc_din_s;
  logic        verify_r, verify_s;
  logic [7:0]  vdata_r, vdata_s;
  logic        busy_r, done_r, rd_valid_r, wr_ready_r, fc_read_r, fc_write_r;
  logic        byte_done_s, gap_done_s;

  // Next-state and datapath update logic.
  always_comb begin
    state_s     = state_r;
    dir_s       = dir_r;
    addr_s      = addr_r;
    remaining_s = remaining_r;
    timer_s     = timer_r;
    error_s     = error_r;
    rd_data_s   = rd_data_r;
    fc_din_s    = fc_din_r;
    verify_s    = verify_r;
    vdata_s     = vdata_r;
    byte_done_s = 1'b0;
    gap_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          dir_s       = dir;
          addr_s      = base_addr;
          remaining_s = len;
          error_s     = 1'b0;
          verify_s    = 1'b0;
          if (len == 16'd0) begin
            state_s = DONE;
          end else if (dir) begin
            state_s = GET;
          end else begin
            state_s = REQ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      GET: begin
        if (wr_valid && wr_ready_r) begin
          fc_din_s = wr_data;
          state_s  = REQ;
        end else begin
          state_s = GET;
        end
      end
      REQ: begin
        timer_s = 16'd0;
        state_s = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (fc_busy) begin
          state_s = WAIT_DONE;
        end else if (timer_r == ACK_LAST) begin
          error_s = 1'b1;
          state_s = DONE;
        end else begin
          timer_s = timer_r + 16'd1;
        end
      end
      WAIT_DONE: begin
        if (fc_busy) begin
          state_s = WAIT_DONE;
        end else if (verify_r) begin
          vdata_s = fc_dout;
          state_s = VERIFY;
        end else if (!dir_r) begin
          rd_data_s = fc_dout;
          state_s   = DELIVER;
        end else if (GAP_EN) begin
          timer_s = 16'd0;
          state_s = GAP;
        end else begin
          gap_done_s = 1'b1;
        end
      end
      DELIVER: begin
        if (rd_ready && rd_valid_r) begin
          byte_done_s = 1'b1;
        end else begin
          state_s = DELIVER;
        end
      end
      GAP: begin
        if (timer_r == GAP_LAST) begin
          gap_done_s = 1'b1;
        end else begin
          timer_s = timer_r + 16'd1;
        end
      end
      VERIFY: begin
        verify_s = 1'b0;
        if (vdata_r != fc_din_r) begin
          error_s = 1'b1;
          state_s = DONE;
        end else begin
          byte_done_s = 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // A finished write either re-reads the same byte or retires it.
    if (gap_done_s) begin
`ifdef FLASH_SEQ_VERIFY_EN
      verify_s = 1'b1;
      state_s  = REQ;
`else
      byte_done_s = 1'b1;
`endif
    end else begin
    end

    if (byte_done_s) begin
      addr_s      = addr_r + 16'd1;
      remaining_s = remaining_r - 16'd1;
      if (remaining_r == 16'd1) begin
        state_s = DONE;
      end else if (dir_r) begin
        state_s = GET;
      end else begin
        state_s = REQ;
      end
    end else begin
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers; outputs are decoded from the next state so they line up with state_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_r       <= 1'b0;
      addr_r      <= 16'd0;
      remaining_r <= 16'd0;
      timer_r     <= 16'd0;
      error_r     <= 1'b0;
      rd_data_r   <= 8'd0;
      fc_din_r    <= 8'd0;
      verify_r    <= 1'b0;
      vdata_r     <= 8'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rd_valid_r  <= 1'b0;
      wr_ready_r  <= 1'b0;
      fc_read_r   <= 1'b0;
      fc_write_r  <= 1'b0;
    end else begin
      dir_r       <= dir_s;
      addr_r      <= addr_s;
      remaining_r <= remaining_s;
      timer_r     <= timer_s;
      error_r     <= error_s;
      rd_data_r   <= rd_data_s;
      fc_din_r    <= fc_din_s;
      verify_r    <= verify_s;
      vdata_r     <= vdata_s;
      busy_r      <= (state_s != IDLE);
      done_r      <= (state_s == DONE);
      rd_valid_r  <= (state_s == DELIVER);
      wr_ready_r  <= (state_s == GET);
      fc_read_r   <= (state_s == REQ) && (!dir_s || verify_s);
      fc_write_r  <= (state_s == REQ) && dir_s && !verify_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign error    = error_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign wr_ready = wr_ready_r;
  assign fc_read  = fc_read_r;
  assign fc_write = fc_write_r;
  assign fc_addr  = addr_r;
  assign fc_din   = fc_din_r;

endmodule

// File: tb/tb_flash_seq.sv
// Self-checking bench for flash_seq: random flash controller model plus
// a spec-level reference for addresses, data, gaps and timeouts.
module tb_flash_seq;

  localparam int ACK_TIMEOUT = 4;
  localparam int WRITE_GAP   = 16;
`ifdef FLASH_SEQ_VERIFY_EN
  localparam int VFY = 1;
`else
  localparam int VFY = 0;
`endif

  logic        clk, reset, start, dir, rd_ready, wr_valid, fc_busy;
  logic [15:0] base_addr, len;
  logic [7:0]  wr_data, fc_dout;
  logic        busy, done, error, rd_valid, wr_ready, fc_read, fc_write;
  logic [7:0]  rd_data, fc_din;
  logic [15:0] fc_addr;

  int errors = 0;
  int checks = 0;

  logic        fm_no_ack = 1'b0;
  logic        fm_corrupt = 1'b0;
  logic [7:0]  fm_mem  [logic [15:0]];
  logic [7:0]  ref_mem [logic [15:0]];

  logic [7:0]  got_rd[$];
  logic [15:0] rd_req_q[$];
  logic [15:0] wr_req_q[$];
  logic [7:0]  wr_din_q[$];
  logic [7:0]  wq[$];
  int          done_cnt, done_cyc, first_req, gap_min, stall_bad, stall_seen;
  logic        err_at_done;

  flash_seq #(.ACK_TIMEOUT(ACK_TIMEOUT), .WRITE_GAP(WRITE_GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .base_addr(base_addr),
    .len(len), .busy(busy), .done(done), .error(error), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .fc_read(fc_read),
    .fc_write(fc_write), .fc_addr(fc_addr), .fc_din(fc_din),
    .fc_dout(fc_dout), .fc_busy(fc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flash controller model: random ack delay and busy length; never acks when fm_no_ack.
  initial begin
    int phase, cnt;
    logic [15:0] a;
    logic [7:0]  d;
    logic        r;
    fc_busy = 1'b0;
    fc_dout = 8'h00;
    phase = 0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        fc_busy = 1'b0;
        phase = 0;
      end else if (phase == 0) begin
        if (!fm_no_ack && (fc_read || fc_write)) begin
          a = fc_addr; d = fc_din; r = fc_read;
          cnt = $urandom_range(0, 2);
          phase = 1;
        end
      end else if (phase == 1) begin
        if (cnt == 0) begin
          fc_busy = 1'b1;
          cnt = $urandom_range(0, 3);
          phase = 2;
        end else cnt--;
      end else begin
        if (cnt == 0) begin
          if (r) fc_dout = fm_corrupt ? 8'h00 : (fm_mem.exists(a) ? fm_mem[a] : (a[7:0] ^ 8'hA5));
          else fm_mem[a] = d;
          fc_busy = 1'b0;
          phase = 0;
        end else cnt--;
      end
    end
  end

  function automatic logic [7:0] exp_byte(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    else return a[7:0] ^ 8'hA5;
  endfunction

  // Start one burst, drive handshakes, record everything the DUT does until done (or budget).
  task automatic run_burst(input logic d, input logic [15:0] b, input logic [15:0] n,
                           input int stall_idx, input bit rand_hs, input int budget);
    int cyc, post, n_acc, gap_start;
    logic busy_prev, last_write, in_stall;
    logic [7:0] hold;
    got_rd.delete(); rd_req_q.delete(); wr_req_q.delete(); wr_din_q.delete();
    done_cnt = 0; done_cyc = -1; first_req = -1; gap_min = 1000000;
    stall_bad = 0; stall_seen = 0; err_at_done = 1'b0;
    cyc = 0; post = 0; n_acc = 0; gap_start = -1;
    busy_prev = 1'b0; last_write = 1'b0; in_stall = 1'b0; hold = 8'h00;
    @(negedge clk);
    start = 1'b1; dir = d; base_addr = b; len = n;
    @(negedge clk);
    start = 1'b0;
    while (cyc < budget && post < 3) begin
      if ((fc_read || fc_write || done) && gap_start >= 0) begin
        if (cyc - gap_start < gap_min) gap_min = cyc - gap_start;
        gap_start = -1;
      end
      if (fc_read) begin
        rd_req_q.push_back(fc_addr); last_write = 1'b0;
        if (first_req < 0) first_req = cyc;
      end
      if (fc_write) begin
        wr_req_q.push_back(fc_addr); wr_din_q.push_back(fc_din); last_write = 1'b1;
        if (first_req < 0) first_req = cyc;
      end
      if (done) begin
        done_cnt++; done_cyc = cyc; err_at_done = error;
      end
      if (busy_prev && !fc_busy && last_write) gap_start = cyc;
      busy_prev = fc_busy;
      if (in_stall && (!rd_valid || rd_data !== hold || fc_read)) stall_bad++;
      if (rd_valid && n_acc == stall_idx && stall_seen < 10) begin
        if (!in_stall) hold = rd_data;
        in_stall = 1'b1; rd_ready = 1'b0; stall_seen++;
      end else begin
        in_stall = 1'b0;
        rd_ready = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (rd_valid && rd_ready) begin got_rd.push_back(rd_data); n_acc++; end
      if (wq.size() > 0) begin
        wr_valid = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
        wr_data = wq[0];
        if (wr_valid && wr_ready) void'(wq.pop_front());
      end else wr_valid = 1'b0;
      if (done_cnt > 0) post++;
      @(negedge clk);
      cyc++;
    end
    rd_ready = 1'b0;
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dir = 1'b0; base_addr = 16'h0; len = 16'h0;
    rd_ready = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, rd_valid, wr_ready, fc_read, fc_write, rd_data, fc_addr, fc_din} !== 39'd0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0", {busy, done, error, rd_valid, wr_ready, fc_read, fc_write, rd_data, fc_addr, fc_din});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, fc_read, fc_write, rd_valid} !== 5'd0) begin
      errors++; $display("FAIL idle_after_reset: got %b required 00000", {busy, done, fc_read, fc_write, rd_valid});
    end
  endtask

  task automatic test_read_basic();
    run_burst(1'b0, 16'h0010, 16'd3, -1, 1'b0, 2000);
    checks++; if (got_rd.size() != 3) begin errors++; $display("FAIL rd_count: got %0d required 3", got_rd.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_rd[i] !== exp_byte(16'h0010 + 16'(i))) begin errors++; $display("FAIL rd_data[%0d]: got %h required %h", i, got_rd[i], exp_byte(16'h0010 + 16'(i))); end
      checks++;
      if (rd_req_q[i] !== 16'h0010 + 16'(i)) begin errors++; $display("FAIL rd_addr[%0d]: got %h required %h", i, rd_req_q[i], 16'h0010 + 16'(i)); end
    end
    checks++; if (rd_req_q.size() != 3 || wr_req_q.size() != 0) begin errors++; $display("FAIL rd_req_count: got %0d/%0d required 3/0", rd_req_q.size(), wr_req_q.size()); end
    checks++; if (done_cnt != 1 || err_at_done !== 1'b0) begin errors++; $display("FAIL rd_done: got %0d err %b required 1 err 0", done_cnt, err_at_done); end
  endtask

  task automatic test_read_stall();
    logic [15:0] b;
    b = 16'($urandom_range(0, 16'h0fff)) + 16'h1000;
    run_burst(1'b0, b, 16'd3, 1, 1'b0, 2000);
    checks++; if (stall_seen != 10 || stall_bad != 0) begin errors++; $display("FAIL stall_hold: got seen %0d bad %0d required 10/0", stall_seen, stall_bad); end
    checks++; if (got_rd.size() != 3 || rd_req_q.size() != 3) begin errors++; $display("FAIL stall_count: got %0d/%0d required 3/3", got_rd.size(), rd_req_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_rd[i] !== exp_byte(b + 16'(i))) begin errors++; $display("FAIL stall_data[%0d]: got %h required %h", i, got_rd[i], exp_byte(b + 16'(i))); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_write_wrap();
    logic [7:0] bytes [2];
    bytes[0] = 8'h11; bytes[1] = 8'h22;
    wq.delete(); wq.push_back(bytes[0]); wq.push_back(bytes[1]);
    run_burst(1'b1, 16'hFFFF, 16'd2, -1, 1'b0, 2000);
    checks++; if (wr_req_q.size() != 2) begin errors++; $display("FAIL wr_count: got %0d required 2", wr_req_q.size()); end
    checks++; if (wr_req_q[0] !== 16'hFFFF || wr_req_q[1] !== 16'h0000) begin errors++; $display("FAIL wr_addr: got %h,%h required ffff,0000", wr_req_q[0], wr_req_q[1]); end
    checks++; if (wr_din_q[0] !== bytes[0] || wr_din_q[1] !== bytes[1]) begin errors++; $display("FAIL wr_din: got %h,%h required 11,22", wr_din_q[0], wr_din_q[1]); end
    checks++; if (gap_min < WRITE_GAP) begin errors++; $display("FAIL wr_gap: got %0d idle cycles required >= %0d", gap_min, WRITE_GAP); end
    checks++; if (rd_req_q.size() != 2 * VFY || got_rd.size() != 0) begin errors++; $display("FAIL wr_reads: got %0d/%0d required %0d/0", rd_req_q.size(), got_rd.size(), 2 * VFY); end
    checks++; if (done_cnt != 1 || err_at_done !== 1'b0) begin errors++; $display("FAIL wr_done: got %0d err %b required 1 err 0", done_cnt, err_at_done); end
    ref_mem[16'hFFFF] = bytes[0];
    ref_mem[16'h0000] = bytes[1];
  endtask

  task automatic test_timeout();
    logic [15:0] b;
    b = 16'($urandom_range(16'h2000, 16'h2fff));
    fm_no_ack = 1'b1;
    run_burst(1'b0, b, 16'd3, -1, 1'b0, 500);
    fm_no_ack = 1'b0;
    checks++; if (done_cnt != 1 || err_at_done !== 1'b1) begin errors++; $display("FAIL to_done: got %0d err %b required 1 err 1", done_cnt, err_at_done); end
    checks++; if (rd_req_q.size() != 1 || rd_req_q[0] !== b) begin errors++; $display("FAIL to_req: got %0d reqs at %h required 1 at %h", rd_req_q.size(), rd_req_q[0], b); end
    checks++; if (done_cyc - first_req != ACK_TIMEOUT + 1) begin errors++; $display("FAIL to_latency: got %0d required %0d", done_cyc - first_req, ACK_TIMEOUT + 1); end
    checks++; if (error !== 1'b1 || got_rd.size() != 0) begin errors++; $display("FAIL to_sticky: got err %b rd %0d required 1/0", error, got_rd.size()); end
    run_burst(1'b0, 16'h0000, 16'd0, -1, 1'b0, 100);
    checks++; if (done_cnt != 1 || err_at_done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL empty_burst: got done %0d err %b/%b required 1 0/0", done_cnt, err_at_done, error); end
    checks++; if (rd_req_q.size() + wr_req_q.size() != 0) begin errors++; $display("FAIL empty_reqs: got %0d required 0", rd_req_q.size() + wr_req_q.size()); end
  endtask

  task automatic test_reset_mid();
    int k, bad;
    @(negedge clk);
    start = 1'b1; dir = 1'b0; base_addr = 16'h0200; len = 16'd2; rd_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!fc_busy && k < 50) begin @(negedge clk); k++; end
    checks++; if (fc_busy !== 1'b1) begin errors++; $display("FAIL rst_mid_ack: got busy %b required 1", fc_busy); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, error, rd_valid, wr_ready, fc_read, fc_write, rd_data, fc_addr, fc_din} !== 39'd0) begin
      errors++; $display("FAIL rst_mid_outputs: got %h required 0", {busy, done, error, rd_valid, wr_ready, fc_read, fc_write, rd_data, fc_addr, fc_din});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fc_read || fc_write || rd_valid || busy || done) bad++;
    end
    rd_ready = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d active cycles required 0", bad); end
    run_burst(1'b0, 16'h0300, 16'd2, -1, 1'b1, 2000);
    checks++; if (got_rd.size() != 2 || got_rd[0] !== exp_byte(16'h0300) || got_rd[1] !== exp_byte(16'h0301)) begin
      errors++; $display("FAIL rst_mid_restart: got %0d bytes %h,%h required 2 %h,%h", got_rd.size(), got_rd[0], got_rd[1], exp_byte(16'h0300), exp_byte(16'h0301));
    end
    checks++; if (done_cnt != 1 || err_at_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %0d err %b required 1 err 0", done_cnt, err_at_done); end
  endtask

  task automatic test_random();
    logic d;
    logic [15:0] b, n, a;
    logic [7:0] exp_w[$];
    for (int t = 0; t < 8; t++) begin
      d = 1'($urandom_range(0, 1));
      b = (t % 3 == 0) ? 16'hFFFE : 16'($urandom);
      n = 16'($urandom_range(1, 5));
      wq.delete(); exp_w.delete();
      if (d) for (int i = 0; i < int'(n); i++) begin exp_w.push_back(8'($urandom)); wq.push_back(exp_w[i]); end
      run_burst(d, b, n, -1, 1'b1, 4000);
      checks++; if (done_cnt != 1 || err_at_done !== 1'b0) begin errors++; $display("FAIL rand_done[%0d]: got %0d err %b required 1 err 0", t, done_cnt, err_at_done); end
      if (!d) begin
        checks++; if (got_rd.size() != int'(n) || rd_req_q.size() != int'(n) || wr_req_q.size() != 0) begin
          errors++; $display("FAIL rand_rd_count[%0d]: got %0d/%0d/%0d required %0d/%0d/0", t, got_rd.size(), rd_req_q.size(), wr_req_q.size(), n, n);
        end
        for (int i = 0; i < int'(n); i++) begin
          a = b + 16'(i);
          checks++; if (got_rd[i] !== exp_byte(a) || rd_req_q[i] !== a) begin
            errors++; $display("FAIL rand_rd[%0d.%0d]: got %h@%h required %h@%h", t, i, got_rd[i], rd_req_q[i], exp_byte(a), a);
          end
        end
      end else begin
        checks++; if (wr_req_q.size() != int'(n) || rd_req_q.size() != VFY * int'(n) || got_rd.size() != 0) begin
          errors++; $display("FAIL rand_wr_count[%0d]: got %0d/%0d/%0d required %0d/%0d/0", t, wr_req_q.size(), rd_req_q.size(), got_rd.size(), n, VFY * int'(n));
        end
        for (int i = 0; i < int'(n); i++) begin
          a = b + 16'(i);
          checks++; if (wr_req_q[i] !== a || wr_din_q[i] !== exp_w[i]) begin
            errors++; $display("FAIL rand_wr[%0d.%0d]: got %h@%h required %h@%h", t, i, wr_din_q[i], wr_req_q[i], exp_w[i], a);
          end
          ref_mem[a] = exp_w[i];
        end
        checks++; if (gap_min < WRITE_GAP) begin errors++; $display("FAIL rand_gap[%0d]: got %0d required >= %0d", t, gap_min, WRITE_GAP); end
      end
    end
  endtask

`ifdef FLASH_SEQ_VERIFY_EN
  task automatic test_verify();
    wq.delete(); wq.push_back(8'h5A); wq.push_back(8'h33); wq.push_back(8'h44);
    fm_corrupt = 1'b1;
    run_burst(1'b1, 16'h0400, 16'd3, -1, 1'b0, 2000);
    fm_corrupt = 1'b0;
    wq.delete();
    checks++; if (done_cnt != 1 || err_at_done !== 1'b1) begin errors++; $display("FAIL vfy_done: got %0d err %b required 1 err 1", done_cnt, err_at_done); end
    checks++; if (wr_req_q.size() != 1 || wr_din_q[0] !== 8'h5A) begin errors++; $display("FAIL vfy_writes: got %0d din %h required 1 din 5a", wr_req_q.size(), wr_din_q[0]); end
    checks++; if (rd_req_q.size() != 1 || rd_req_q[0] !== 16'h0400 || got_rd.size() != 0) begin
      errors++; $display("FAIL vfy_read: got %0d at %h rd %0d required 1 at 0400 rd 0", rd_req_q.size(), rd_req_q[0], got_rd.size());
    end
    ref_mem[16'h0400] = 8'h5A;
  endtask
`endif

  initial begin
    test_reset();
    test_read_basic();
    test_read_stall();
    test_write_wrap();
    test_timeout();
    test_reset_mid();
    test_random();
`ifdef FLASH_SEQ_VERIFY_EN
    test_verify();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flash_seq.md
Name: flash_seq

Overview:
Burst sequencer that sits directly upstream of the SPI flash controller and drives its single-byte read/write request interface. Given a start address, a length and a direction, it issues one flash request per byte and increments the address after each byte. It delivers read bytes on a valid/ready output stream and accepts write bytes from a valid/ready input stream. Writes insert a programmable post-write gap. Controller acknowledges are supervised by a timeout.

Parameters:
ACK_TIMEOUT, 4, cycles allowed after a request for fc_busy to rise before an error abort (minimum 1)
WRITE_GAP, 16, idle cycles inserted after each completed flash write (0 = no gap)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle start pulse; sampled only in IDLE
dir  input  1  0 = read burst, 1 = write burst; sampled with start
base_addr  input  16  first byte address; sampled with start
len  input  16  byte count; sampled with start; 0 = empty burst
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst end (normal, empty or aborted)
error  output  1  sticky abort flag; cleared when the next start is accepted
rd_data  output  8  read byte
rd_valid  output  1  rd_data valid
rd_ready  input  1  consumer accepts rd_data
wr_data  input  8  byte to program
wr_valid  input  1  wr_data valid
wr_ready  output  1  sequencer accepts wr_data
fc_read  output  1  read request to flash controller
fc_write  output  1  write request to flash controller
fc_addr  output  16  request address
fc_din  output  8  write data to flash controller
fc_dout  input  8  read data from flash controller
fc_busy  input  1  flash controller busy

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset forces IDLE from any state, including mid-burst; no further request is issued after reset.
- States: IDLE, GET, REQ, WAIT_ACK, WAIT_DONE, DELIVER, GAP, VERIFY (only with the optional feature), DONE.
- IDLE:
  - start=1 latches dir, base_addr into addr, and len into remaining. It clears error and sets busy=1 on the next cycle.
  - If len=0, go to DONE. If dir=0, go to REQ. If dir=1, go to GET.
  - start is ignored in every other state.
- GET:
  - wr_ready=1.
  - On wr_valid&&wr_ready, latch wr_data into fc_din, drop wr_ready the next cycle, and go to REQ.
- REQ:
  - fc_read (dir=0) or fc_write (dir=1) is high for exactly one cycle, with fc_addr=addr. Then go to WAIT_ACK.
  - fc_read and fc_write are never high together.
  - fc_addr and fc_din stay stable from REQ until WAIT_DONE exits.
- WAIT_ACK:
  - Wait for fc_busy=1, then go to WAIT_DONE.
  - If fc_busy has not risen after ACK_TIMEOUT cycles in this state, set error=1 and go to DONE.
- WAIT_DONE: wait for fc_busy=0.
  - Read: capture fc_dout into rd_data, set rd_valid=1 on the next cycle, go to DELIVER.
  - Write: go to GAP.
- DELIVER:
  - rd_valid holds until rd_ready is seen.
  - On accept: rd_valid<=0, addr<=addr+1, remaining<=remaining-1. Go to DONE if remaining was 1, otherwise go to REQ.
- GAP:
  - Count WRITE_GAP cycles (zero cycles when WRITE_GAP=0), then addr+1 and remaining-1.
  - Go to DONE if remaining was 1, otherwise go to GET.
- DONE: done=1 for one cycle, busy<=0, then IDLE.
- Arithmetic:
  - addr is 16 bits and wraps 0xFFFF -> 0x0000 without error.
  - remaining is 16 bits, so len=65535 is a legal burst.
- Latency: minimum three cycles from fc_busy falling to the next request for back-to-back reads with rd_ready held high.
- Aborts leave addr and remaining un-advanced for the failing byte.

Optional Feature:
Macro FLASH_SEQ_VERIFY_EN.
- Defined:
  - After each write's GAP, the sequencer issues a read request at the same addr through REQ/WAIT_ACK/WAIT_DONE, then enters VERIFY.
  - VERIFY compares fc_dout with fc_din. On mismatch it sets error=1 and goes to DONE without advancing addr or remaining. On match it advances as in GAP.
  - Verify reads are never presented on rd_valid.
- Undefined: no read-back is performed; the only error source is the acknowledge timeout.

Test Plan:
- Read burst, base_addr=0x0010, len=3, model returns addr[7:0]^0xA5 -> rd_data 0xB5, 0xB4, 0xB7 in order; three fc_read pulses at 0x0010–0x0012; one done pulse; error=0.
- Read burst with rd_ready held low for 10 cycles on byte 1 -> rd_valid and rd_data stable throughout; no fc_read issued until accept.
- Write burst, base_addr=0xFFFF, len=2, bytes 0x11 and 0x22 -> fc_write at 0xFFFF then 0x0000 with fc_din 0x11 then 0x22; at least WRITE_GAP idle cycles after each write; one done pulse.
- Model never raises fc_busy, ACK_TIMEOUT=4 -> error=1 and done after 4 WAIT_ACK cycles; the next start with len=0 clears error and pulses done.
- Assert reset in WAIT_DONE of a read -> all outputs 0 next cycle; state IDLE; no rd_valid; a new start works normally.
- Verify build, model corrupts the read-back (returns 0x00 for a written 0x5A) -> error=1 and done; no further fc_write is issued.
